i2c_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one i2c_master write engine among NUM_REQ requesters.
- Each requester presents a 7-bit slave address and an 8-bit data byte.
- The arbiter selects one requester, launches the master, and waits for completion or timeout. It then returns a done/err pulse to the owning requester.
- Sits between on-chip clients (sensor pollers, config loaders) and i2c_master.

---
 rtl/i2c_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_req_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one i2c_master write
//             engine among NUM_REQ requesters. Grants one requester, launches
//             the master, waits for completion or timeout, and returns a
//             done/err pulse to the owner.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*7-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_data,
    output logic                 m_abort,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_nack,
    output logic                 busy,
    output logic [IDX_W-1:0]     cur_idx,
    output logic [2:0]           state
);

    // Counter only ever needs to represent values up to TIMEOUT_CYC-1.
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_oh_one = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [IDX_W-1:0]     r_last, w_last_nxt;
    logic [6:0]           r_addr, w_addr_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic [NUM_REQ-1:0]   r_err, w_err_nxt;
    logic                 r_m_start, w_m_start_nxt;
    logic                 r_m_abort, w_m_abort_nxt;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [6:0]           w_sel_addr;
    logic [7:0]           w_sel_data;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Round-robin pick: the requester closest after r_last (with wrap) wins.
    always_comb begin : p_rr_pick
        int d;
        int best_d;
        d       = 0;
        best_d  = NUM_REQ;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(r_last) - 1;
            if (d < 0) begin
                d = d + NUM_REQ;
            end
            if (req[i] && (d < best_d)) begin
                best_d  = d;
                w_win   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

    // Extract the winner's address/data slice from the flattened buses.
    always_comb begin : p_slice_sel
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_sel_addr = req_addr[i*7 +: 7];
                w_sel_data = req_data[i*8 +: 8];
            end
        end
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin : p_fsm_comb
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_last_nxt    = r_last;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = '0;
        w_done_nxt    = '0;
        w_err_nxt     = '0;
        w_m_start_nxt = 1'b0;
        w_m_abort_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_found && !m_busy) begin
                    w_idx_nxt     = w_win;
                    w_addr_nxt    = w_sel_addr;
                    w_data_nxt    = w_sel_data;
                    w_gnt_nxt     = c_oh_one << w_win;
                    w_m_start_nxt = 1'b1;
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                // m_done is deliberately not looked at here.
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (m_done) begin
                    // Completion beats a coincident timeout.
                    w_done_nxt  = c_oh_one << r_idx;
                    w_err_nxt   = m_nack ? (c_oh_one << r_idx) : '0;
                    w_state_nxt = S_RESP;
                end else if (w_cnt_inc == c_cnt_last) begin
                    w_m_abort_nxt = 1'b1;
                    w_done_nxt    = c_oh_one << r_idx;
                    w_err_nxt     = c_oh_one << r_idx;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                w_last_nxt  = r_idx;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_last    <= c_last_rst;
            r_addr    <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_m_start <= 1'b0;
            r_m_abort <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_last    <= w_last_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_m_start <= w_m_start_nxt;
            r_m_abort <= w_m_abort_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign m_start = r_m_start;
    assign m_abort = r_m_abort;
    assign m_addr  = r_addr;
    assign m_data  = r_data;
    assign busy    = (r_state != S_IDLE);
    assign cur_idx = r_idx;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_req_arbiter
//  Purpose  : Self-checking bench for i2c_req_arbiter. The bench plays the
//             i2c_master and the requesters; expectations come from a
//             round-robin model and cycle arithmetic on the transaction timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N*7-1:0] req_addr;
    logic [N*8-1:0] req_data;
    logic [N-1:0] gnt, done, err;
    logic         m_start, m_abort;
    logic [6:0]   m_addr;
    logic [7:0]   m_data;
    logic         m_busy, m_done, m_nack;
    logic         busy;
    logic [1:0]   cur_idx;
    logic [2:0]   state;

    int checks = 0;
    int errors = 0;
    int mdl_last;

    i2c_req_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_abort  (m_abort),
        .m_busy   (m_busy),
        .m_done   (m_done),
        .m_nack   (m_nack),
        .busy     (busy),
        .cur_idx  (cur_idx),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: list requesters in priority order after 'last'.
    function automatic int mdl_pick(input logic [N-1:0] r, input int last);
        int order[$];
        for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
        foreach (order[j]) begin
            if (((r >> order[j]) & 4'd1) != 4'd0) return order[j];
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return 4'd1 << i;
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            req_addr[i*7 +: 7] = 7'($urandom);
            req_data[i*8 +: 8] = 8'($urandom);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},     32'(gnt),     32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
        chk({tag, "_m_start"}, 32'(m_start), 32'd0);
        chk({tag, "_m_abort"}, 32'(m_abort), 32'd0);
        chk({tag, "_m_addr"},  32'(m_addr),  32'd0);
        chk({tag, "_m_data"},  32'(m_data),  32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_cur_idx"}, 32'(cur_idx), 32'd0);
        chk({tag, "_state"},   32'(state),   32'd0);
    endtask

    // One full transaction from an IDLE cycle. START is cycle 1; m_done is
    // driven in cycle 1+dly so done appears in cycle 2+dly. With no m_done by
    // cycle TO the master is aborted and done/err/m_abort appear in cycle TO+1.
    // dly >= TO means the bench never answers.
    task automatic run_txn(input logic [N-1:0] rq, input int dly, input bit nack,
                           input bit hold, output int win);
        int resp_c;
        bit to;
        logic [6:0] ea;
        logic [7:0] ed;
        logic [N-1:0] eoh;
        win    = mdl_pick(rq, mdl_last);
        ea     = req_addr[win*7 +: 7];
        ed     = req_data[win*8 +: 8];
        eoh    = oh(win);
        to     = (dly >= TO);
        resp_c = to ? TO + 1 : dly + 2;
        req    = rq;
        step();
        chk("start_gnt",     32'(gnt),     32'(eoh));
        chk("start_m_start", 32'(m_start), 32'd1);
        chk("start_m_addr",  32'(m_addr),  32'(ea));
        chk("start_m_data",  32'(m_data),  32'(ed));
        chk("start_state",   32'(state),   32'd1);
        if (!hold) begin
            req = '0;
            rand_payload();
        end
        for (int c = 2; c <= resp_c; c++) begin
            step();
            if (c < resp_c) begin
                chk("wait_state",   32'(state),   32'd2);
                chk("wait_m_abort", 32'(m_abort), 32'd0);
                m_done = (!to && (c == dly + 1));
                m_nack = m_done ? nack : 1'b0;
            end else begin
                m_done = 1'b0;
                m_nack = 1'b0;
                chk("resp_state",   32'(state),   32'd3);
                chk("resp_done",    32'(done),    32'(eoh));
                chk("resp_err",     32'(err),     (to || nack) ? 32'(eoh) : 32'd0);
                chk("resp_m_abort", 32'(m_abort), 32'(to));
                chk("resp_m_addr",  32'(m_addr),  32'(ea));
                chk("resp_m_data",  32'(m_data),  32'(ed));
                chk("resp_cur_idx", 32'(cur_idx), 32'(win));
                chk("resp_gnt",     32'(gnt),     32'd0);
            end
        end
        mdl_last = win;
        step();
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_busy",  32'(busy),  32'd0);
        chk("idle_done",  32'(done),  32'd0);
    endtask

    initial begin
        int w;
        int rr_order[5];
        rr_order = '{0, 1, 2, 3, 0};
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_nack   = 1'b0;
        mdl_last = N - 1;

        // Reset state
        step();
        step();
        chk_all_zero("rst");
        reset = 1'b0;
        step();
        chk("rst_idle_state", 32'(state), 32'd0);

        // Single request from requester 1
        req_addr[1*7 +: 7] = 7'h50;
        req_data[1*8 +: 8] = 8'h3C;
        run_txn(4'b0010, 12, 1'b0, 1'b0, w);
        chk("single_idx", 32'(cur_idx), 32'd1);

        // Round robin with all requesters held high from a fresh reset
        reset = 1'b1;
        step();
        reset    = 1'b0;
        mdl_last = N - 1;
        rand_payload();
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, 3 + k, 1'b0, 1'b1, w);
            chk("rr_order", 32'(cur_idx), 32'(rr_order[k]));
        end
        req = '0;

        // NACK from requester 2, then requester 3 is next in line
        rand_payload();
        req_addr[2*7 +: 7] = 7'h21;
        run_txn(4'b0100, 6, 1'b1, 1'b0, w);
        chk("nack_idx", 32'(cur_idx), 32'd2);
        run_txn(4'b1101, 4, 1'b0, 1'b0, w);
        chk("after_nack_idx", 32'(cur_idx), 32'd3);

        // Timeout, then coincident m_done/timeout with and without NACK
        rand_payload();
        run_txn(4'(N'($urandom_range(1, 15))), 1000, 1'b0, 1'b0, w);
        run_txn(4'(N'($urandom_range(1, 15))), TO - 1, 1'b1, 1'b0, w);
        run_txn(4'(N'($urandom_range(1, 15))), TO - 1, 1'b0, 1'b0, w);
        run_txn(4'(N'($urandom_range(1, 15))), TO - 2, 1'b1, 1'b0, w);

        // Master busy holds off the grant
        m_busy = 1'b1;
        req    = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mbusy_gnt",   32'(gnt),   32'd0);
            chk("mbusy_state", 32'(state), 32'd0);
        end
        m_busy = 1'b0;
        run_txn(4'b0001, 5, 1'b0, 1'b0, w);
        chk("mbusy_idx", 32'(cur_idx), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 24; k++) begin
            rand_payload();
            run_txn(4'($urandom_range(1, 15)), int'($urandom_range(1, 20)),
                    1'($urandom_range(0, 1)), 1'b0, w);
        end

        // Reset in the middle of WAIT
        rand_payload();
        req = 4'b0100;
        step();
        req = '0;
        step();
        step();
        chk("mid_wait_state", 32'(state), 32'd2);
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step();
        chk("rst_hold_state", 32'(state), 32'd0);
        reset    = 1'b0;
        mdl_last = N - 1;
        run_txn(4'b1000, 5, 1'b0, 1'b0, w);
        chk("post_rst_idx", 32'(cur_idx), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
